// File: rtl/sdram_burst_writer.sv
// Collects upstream words into a one-burst buffer and replays them to the SDRAM
// writer port as an address beat followed by BURST_LENGTH data beats.
module sdram_burst_writer #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [1:0]            s_dqm,
    input  logic                  s_last,
    output logic                  writer_valid,
    input  logic                  writer_ready,
    output logic [ADDR_WIDTH-1:0] writer_addr,
    output logic [DATA_WIDTH-1:0] writer_data,
    output logic [1:0]            writer_dqm_o,
    output logic                  busy_o,
    output logic [15:0]           burst_cnt_o
);

    localparam int IDX_W = $clog2(BURST_LENGTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BURST_LENGTH - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(BURST_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_LENGTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BURST_LENGTH - 1));

    typedef enum logic [1:0] {
        FILL = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic [DATA_WIDTH+1:0] buffer [BURST_LENGTH];

    logic                  accept;
    logic                  start_ok;
    logic                  fill_done;
    logic [ADDR_WIDTH-1:0] ptr_eff;
    logic [IDX_W-1:0]      fetch_idx;
    logic                  fetch_pad;
    logic [DATA_WIDTH+1:0] fetch_word;

    assign s_ready   = (state == FILL) && !rst;
    assign accept    = s_valid && s_ready;
    assign start_ok  = start_i && (state == FILL) && (cnt == '0);
    assign ptr_eff   = start_ok ? (base_addr_i & ALIGN_MASK) : addr_ptr;
    assign fill_done = accept && (s_last || (cnt == CNT_LAST));
    assign busy_o    = (state != FILL) || (cnt != '0);

    // Next beat to present: entry 0 after the address beat, else idx+1; unfilled slots pad with mask 11.
    assign fetch_idx  = (state == ADDR) ? '0 : idx + 1'b1;
    assign fetch_pad  = ({1'b0, fetch_idx} >= cnt);
    assign fetch_word = fetch_pad ? {2'b11, {DATA_WIDTH{1'b0}}} : buffer[fetch_idx];

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[cnt[IDX_W-1:0]] <= {s_dqm, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            cnt          <= '0;
            idx          <= '0;
            addr_ptr     <= '0;
            burst_cnt_o  <= '0;
            writer_valid <= 1'b0;
            writer_addr  <= '0;
            writer_data  <= '0;
            writer_dqm_o <= 2'b11;
        end else begin
            case (state)
                FILL: begin
                    if (start_ok) begin
                        addr_ptr    <= ptr_eff;
                        burst_cnt_o <= '0;
                    end
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (fill_done) begin
                        state        <= ADDR;
                        writer_valid <= 1'b1;
                        writer_addr  <= ptr_eff;
                    end
                end
                ADDR: begin
                    if (writer_ready) begin
                        state        <= DATA;
                        idx          <= '0;
                        writer_data  <= fetch_word[DATA_WIDTH-1:0];
                        writer_dqm_o <= fetch_word[DATA_WIDTH+1:DATA_WIDTH];
                    end
                end
                DATA: begin
                    if (writer_ready) begin
                        if (idx == IDX_LAST) begin
                            state        <= FILL;
                            writer_valid <= 1'b0;
                            writer_dqm_o <= 2'b11;
                            cnt          <= '0;
                            addr_ptr     <= addr_ptr + ADDR_STEP;
                            burst_cnt_o  <= burst_cnt_o + 16'd1;
                        end else begin
                            idx          <= idx + 1'b1;
                            writer_data  <= fetch_word[DATA_WIDTH-1:0];
                            writer_dqm_o <= fetch_word[DATA_WIDTH+1:DATA_WIDTH];
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_writer.sv
// Randomized and directed bench for sdram_burst_writer against a queue-based
// model of the bursts the writer port should see.
module tb_sdram_burst_writer;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [1:0]    s_dqm;
    logic          s_last;
    logic          writer_valid;
    logic          writer_ready;
    logic [AW-1:0] writer_addr;
    logic [DW-1:0] writer_data;
    logic [1:0]    writer_dqm_o;
    logic          busy_o;
    logic [15:0]   burst_cnt_o;

    always #5 clk = ~clk;

    sdram_burst_writer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_dqm        (s_dqm),
        .s_last       (s_last),
        .writer_valid (writer_valid),
        .writer_ready (writer_ready),
        .writer_addr  (writer_addr),
        .writer_data  (writer_data),
        .writer_dqm_o (writer_dqm_o),
        .busy_o       (busy_o),
        .burst_cnt_o  (burst_cnt_o)
    );

    typedef struct {
        bit            is_addr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    dqm;
    } beat_t;

    beat_t         expq[$];
    beat_t         mbuf[$];
    logic [31:0]   wlog[$];
    logic [AW-1:0] mptr;
    logic [15:0]   mburst;
    bit            in_burst;
    int            beats_done;

    int  n_checks;
    int  n_fail;
    int  wr_mode;
    int  ncyc;
    bit  last_acc;
    bit  prev_stall;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic [1:0]    p_dqm;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        mbuf.delete();
        mptr       = '0;
        mburst     = '0;
        in_burst   = 0;
        beats_done = 0;
    endtask

    task automatic form_burst();
        expq.push_back('{1'b1, mptr, 16'h0, 2'b00});
        for (int i = 0; i < BL; i++) begin
            if (i < mbuf.size())
                expq.push_back('{1'b0, 24'h0, mbuf[i].data, mbuf[i].dqm});
            else
                expq.push_back('{1'b0, 24'h0, 16'h0, 2'b11});
        end
        mbuf.delete();
        in_burst = 1;
    endtask

    // One clock: apply ready policy, check outputs against the model, advance the model.
    task automatic step();
        beat_t b;
        bit    idle;
        case (wr_mode)
            0:       writer_ready = 1'b1;
            1:       writer_ready = ~writer_ready;
            default: writer_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (ncyc > 0) begin
            check_val("s_ready", s_ready, !rst && !in_burst);
            check_val("writer_valid", writer_valid, in_burst);
            check_val("busy", busy_o, in_burst || (mbuf.size() != 0));
            check_val("burst_cnt", burst_cnt_o, mburst);
            if (prev_stall) begin
                check_val("stall_addr", writer_addr, p_addr);
                check_val("stall_data", writer_data, p_data);
                check_val("stall_dqm", writer_dqm_o, p_dqm);
            end
        end
        last_acc = 0;
        idle = !in_burst;
        if (rst) begin
            model_reset();
        end else begin
            if (start_i && idle && mbuf.size() == 0) begin
                mptr   = base_addr_i - (base_addr_i % BL);
                mburst = 0;
            end
            if (writer_valid && writer_ready) begin
                if (expq.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    b = expq.pop_front();
                    if (b.is_addr) begin
                        check_val("addr_beat", writer_addr, b.addr);
                        wlog.push_back(32'(writer_addr));
                        beats_done = 0;
                    end else begin
                        check_val("data_beat", writer_data, b.data);
                        check_val("dqm_beat", writer_dqm_o, b.dqm);
                        wlog.push_back({14'h0, writer_dqm_o, writer_data});
                        beats_done++;
                        if (beats_done == BL) begin
                            in_burst = 0;
                            mptr     = mptr + AW'(BL);
                            mburst   = mburst + 16'd1;
                        end
                    end
                end
            end
            if (s_valid && idle) begin
                last_acc = 1;
                mbuf.push_back('{1'b0, 24'h0, s_data, s_dqm});
                if (s_last || mbuf.size() == BL) form_burst();
            end
        end
        prev_stall = writer_valid && !writer_ready && !rst;
        p_addr = writer_addr;
        p_data = writer_data;
        p_dqm  = writer_dqm_o;
        ncyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start_i     = 1'b1;
        base_addr_i = base;
        step();
        start_i     = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [1:0] m, input logic l);
        int budget = 200;
        s_valid = 1'b1;
        s_data  = d;
        s_dqm   = m;
        s_last  = l;
        do begin
            step();
            budget--;
        end while (!last_acc && budget > 0);
        if (!last_acc) check_val("push_timeout", 1, 0);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int budget = 300;
        s_valid = 1'b0;
        while (in_burst && budget > 0) begin
            step();
            budget--;
        end
        if (in_burst) check_val("drain_timeout", 1, 0);
        check_val("queue_empty", expq.size(), 0);
    endtask

    task automatic wait_beats(input int n);
        int budget = 300;
        while (!(in_burst && beats_done == n) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check_val("beat_wait_timeout", 1, 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; ncyc = 0; prev_stall = 0;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0;
        s_valid = 1'b0; s_data = '0; s_dqm = '0; s_last = 1'b0;
        writer_ready = 1'b0; wr_mode = 0;
        model_reset();

        // Reset values
        step();
        step();
        check_val("rst_addr", writer_addr, 0);
        check_val("rst_data", writer_data, 0);
        check_val("rst_dqm", writer_dqm_o, 2'b11);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_sready", s_ready, 0);
        rst = 1'b0;
        #1;
        check_val("rel_sready", s_ready, 1);

        // Full burst at 0x100
        wlog.delete();
        do_start(24'h000100);
        for (int i = 0; i < BL; i++) push_word(16'h1000 + 16'(i), 2'b00, 1'b0);
        drain();
        check_val("full_count", wlog.size(), 9);
        check_val("full_addr", wlog[0], 32'h100);
        for (int i = 0; i < BL; i++) check_val("full_data", wlog[1 + i], 32'h1000 + 32'(i));
        check_val("full_bcnt", burst_cnt_o, 1);

        // Partial burst padded to full length
        wlog.delete();
        push_word(16'h000A, 2'b00, 1'b0);
        push_word(16'h000B, 2'b00, 1'b0);
        push_word(16'h000C, 2'b00, 1'b1);
        drain();
        check_val("part_addr", wlog[0], 32'h108);
        check_val("part_a", wlog[1], 32'h0000A);
        check_val("part_b", wlog[2], 32'h0000B);
        check_val("part_c", wlog[3], 32'h0000C);
        for (int i = 4; i < 9; i++) check_val("part_pad", wlog[i], 32'h30000);

        // Two bursts with writer_ready toggling
        wlog.delete();
        wr_mode = 1;
        do_start(24'h000100);
        for (int i = 0; i < 2 * BL; i++) push_word(16'h2000 + 16'(i), 2'(i), 1'b0);
        drain();
        check_val("tog_count", wlog.size(), 18);
        check_val("tog_addr0", wlog[0], 32'h100);
        check_val("tog_addr1", wlog[9], 32'h108);
        check_val("tog_last", wlog[17], {14'h0, 2'(15), 16'h200F});
        wr_mode = 0;

        // Address wrap, with an unaligned base
        wlog.delete();
        do_start(24'hFFFFFB);
        for (int i = 0; i < 2 * BL; i++) push_word(16'(i), 2'b01, 1'b0);
        drain();
        check_val("wrap_addr0", wlog[0], 32'hFFFFF8);
        check_val("wrap_addr1", wlog[9], 32'h0);
        check_val("wrap_bcnt", burst_cnt_o, 2);

        // Reset during the 4th data beat
        for (int i = 0; i < BL; i++) push_word(16'h3000 + 16'(i), 2'b00, 1'b0);
        wait_beats(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_mid_valid", writer_valid, 0);
        check_val("rst_mid_bcnt", burst_cnt_o, 0);
        wlog.delete();
        for (int i = 0; i < BL; i++) push_word(16'h4000 + 16'(i), 2'b00, 1'b0);
        drain();
        check_val("rst_mid_addr", wlog[0], 32'h0);

        // start_i during DATA is ignored
        wlog.delete();
        do_start(24'h000200);
        for (int i = 0; i < BL; i++) push_word(16'h5000 + 16'(i), 2'b00, 1'b0);
        wait_beats(2);
        do_start(24'h000500);
        drain();
        for (int i = 0; i < BL; i++) push_word(16'h6000 + 16'(i), 2'b10, 1'b0);
        drain();
        check_val("ign_addr0", wlog[0], 32'h200);
        check_val("ign_addr1", wlog[9], 32'h208);

        // Randomized traffic
        wr_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            s_valid     = 1'($urandom_range(0, 1));
            s_data      = 16'($urandom());
            s_dqm       = 2'($urandom_range(0, 3));
            s_last      = ($urandom_range(0, 7) == 0);
            start_i     = ($urandom_range(0, 15) == 0);
            base_addr_i = 24'($urandom());
            step();
        end
        start_i = 1'b0;
        push_word(16'hBEEF, 2'b00, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_burst_writer.md
SDRAM_BURST_WRITER -- requirements
Module: sdram_burst_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: word address width of the SDRAM writer port.
REQ-002 Parameter DATA_WIDTH, default 16: data word width.
REQ-003 Parameter BURST_LENGTH, default 8: data beats per burst; power of two, 2..256.
REQ-004 clk  input  1  block clock; all logic samples on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start_i  input  1  pulse; loads base_addr_i into the address pointer.
REQ-007 base_addr_i  input  ADDR_WIDTH  first burst word address; must be BURST_LENGTH-aligned.
REQ-008 s_valid  input  1  upstream word valid.
REQ-009 s_ready  output  1  upstream word accepted when s_valid && s_ready.
REQ-010 s_data  input  DATA_WIDTH  upstream word.
REQ-011 s_dqm  input  2  per-byte mask for this word; 1 = byte not written.
REQ-012 s_last  input  1  qualifies s_data; the last word of a transfer, forces a flush.
REQ-013 writer_valid  output  1  request to the SDRAM writer port (address or data beat).
REQ-014 writer_ready  input  1  writer port accepts the beat when writer_valid && writer_ready.
REQ-015 writer_addr  output  ADDR_WIDTH  burst start address, meaningful in the address phase.
REQ-016 writer_data  output  DATA_WIDTH  burst data word, meaningful in the data phase.
REQ-017 writer_dqm_o  output  2  per-beat byte mask, meaningful in the data phase.
REQ-018 busy_o  output  1  high while the buffer is non-empty or a burst is in flight.
REQ-019 burst_cnt_o  output  16  count of completed bursts since reset or start_i; wraps modulo 2^16.

Function
REQ-020 The block SHALL implement states FILL, ADDR and DATA, plus a BURST_LENGTH-entry buffer holding {dqm, data}, a fill count cnt (0..BURST_LENGTH) and a beat index idx.
REQ-021 In FILL, the block SHALL assert s_ready=1 and writer_valid=0.
REQ-022 In FILL, each accepted word SHALL be written to buffer[cnt], and cnt SHALL increment.
REQ-023 The block SHALL move FILL->ADDR on the cycle after cnt reaches BURST_LENGTH, or after a word with s_last=1 is accepted.
REQ-024 In ADDR and DATA, the block SHALL hold s_ready=0.
REQ-025 In ADDR, the block SHALL drive writer_valid=1 and writer_addr=addr_ptr.
REQ-026 On the ADDR handshake, the block SHALL move to DATA with idx=0.
REQ-027 In DATA, the block SHALL drive writer_valid=1 and writer_data=buffer[idx].data.
REQ-028 In DATA, writer_dqm_o SHALL be buffer[idx].dqm when idx<cnt, and 2'b11 when idx>=cnt (padding beat, writer_data=0).
REQ-029 On each DATA handshake, idx SHALL increment.
REQ-030 On the handshake with idx=BURST_LENGTH-1, the block SHALL: return to FILL; set cnt=0; increment addr_ptr by BURST_LENGTH, wrapping modulo 2^ADDR_WIDTH; increment burst_cnt_o.
REQ-031 Exactly 1+BURST_LENGTH handshakes SHALL occur per burst; a partial burst is always padded to full length.
REQ-032 writer_valid, writer_addr, writer_data and writer_dqm_o SHALL be registered and SHALL stay stable while writer_valid=1 && writer_ready=0.
REQ-033 Minimum latency from the accept of the final buffered word to writer_valid=1 SHALL be 1 cycle.
REQ-034 start_i SHALL take effect only in FILL with cnt=0: addr_ptr<=base_addr_i, burst_cnt_o<=0.
REQ-035 start_i in any other condition SHALL be ignored.
REQ-036 start_i coincident with an accepted s_valid word SHALL both load the address and accept the word.
REQ-037 Low bits of base_addr_i below log2(BURST_LENGTH) SHALL be forced to zero.
REQ-038 busy_o SHALL be (state!=FILL) || (cnt!=0).

Reset
REQ-039 While rst=1 at a clock edge: state<=FILL; cnt, idx, addr_ptr and burst_cnt_o<=0; writer_valid<=0; writer_addr, writer_data<=0; writer_dqm_o<=2'b11; busy_o=0.
REQ-040 Reset mid-burst SHALL discard buffered data without emitting further beats.
REQ-041 s_ready SHALL be 0 during the cycle rst=1 and SHALL be 1 on the first cycle after release.

Verification
REQ-042 start_i with base 0x000100, then 8 words 0x1000..0x1007 with dqm 00, writer_ready=1 -> one address beat 0x000100; 8 data beats 0x1000..0x1007, dqm 00; burst_cnt_o=1.
REQ-043 3 words (0xA,0xB,0xC), the third with s_last=1 -> address beat, then beats A,B,C with dqm 00, then 5 beats data 0 with dqm 11.
REQ-044 Two consecutive full bursts, writer_ready toggled 1/0 every cycle -> addresses 0x000100 then 0x000108; outputs stable during stalls; no beat lost or duplicated.
REQ-045 base 0xFFFFF8, 2 full bursts -> second burst address 0x000000 (wrap).
REQ-046 rst asserted at the 4th data beat -> writer_valid=0 next cycle; after release, a new 8-word burst goes to address 0x000000.
REQ-047 start_i asserted during DATA state -> ignored; the following burst uses the incremented address.
